// File: rtl/i2c_pkg.sv
// i2c_pkg: shared encodings for the I2C master
// Holds the FSM state encoding, the quarter-phase encoding, the default
// target address and the SCL-low decode shared by the master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_WDATA,
    ST_RDATA,
    ST_ACK2,
    ST_STOP
  } state_e;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_e;

  localparam logic [6:0] DEFAULT_ADDR = 7'h44;

  // START holds SCL released until its last quarter; every other bus bit
  // (including STOP) keeps SCL low for the first half of the bit-time.
  function automatic logic scl_low_f(state_e s, quarter_e q);
    return s != ST_IDLE && (s == ST_START ? q == Q3 : q inside {Q0, Q1});
  endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen: quarter-period tick generator for the I2C master
// Ports: clk, rst_n (async active-low), en (count while high, clear while low),
//        tick (one-cycle pulse every DIV enabled cycles).
module i2c_clk_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && cnt_q == LAST;

  always_comb cnt_d = (!en || tick) ? '0 : cnt_q + W'(1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (one write or one read per request)
// Ports: clk, rst_n (async active-low); start/addr/rw/data_in request inputs;
//        data_out (last read byte), busy, done (1-cycle pulse), ack_err status;
//        sda, scl open-drain bus lines (driven low or released only).
module i2c_master
  import i2c_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  inout  wire               sda,
  inout  wire               scl
);

  localparam int CW = (ADDR_W + 1 > 8) ? $clog2(ADDR_W + 1) : 3;

  state_e          state_q, state_d;
  quarter_e        q_q, q_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d, rx_q, rx_d, data_out_q, data_out_d;
  logic            busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
  logic            ack_q, ack_d;
  logic [1:0]      sda_sync_q;
  logic            sda_low_q, sda_low_d, scl_low_q, scl_low_d;
  logic            tick, accept, bit_end, sample, last_bit, rd;

  i2c_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy_q),
    .tick (tick)
  );

  assign accept   = state_q == ST_IDLE && start;
  assign bit_end  = tick && q_q == Q3;
  assign sample   = tick && q_q == Q1;
  assign last_bit = bit_cnt_q == '0;
  assign rd       = addr_q[0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      q_q        <= Q0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      ack_q      <= 1'b0;
      sda_sync_q <= 2'b11;
      sda_low_q  <= 1'b0;
      scl_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      ack_q      <= ack_d;
      sda_sync_q <= {sda_sync_q[0], sda};
      sda_low_q  <= sda_low_d;
      scl_low_q  <= scl_low_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:            if (start) state_d = ST_START;
      ST_START:           if (bit_end) state_d = ST_ADDR;
      ST_ADDR:            if (bit_end && last_bit) state_d = ST_ACK1;
      ST_ACK1:            if (bit_end) state_d = ack_q ? ST_STOP : rd ? ST_RDATA : ST_WDATA;
      ST_WDATA, ST_RDATA: if (bit_end && last_bit) state_d = ST_ACK2;
      ST_ACK2:            if (bit_end) state_d = ST_STOP;
      ST_STOP:            if (bit_end) state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // The synchronised SDA is stable well before Q2 entry, since the bus only
  // changes at Q0 entry and a quarter is at least two cycles long.
  always_comb begin
    q_d        = busy_q ? (tick ? quarter_e'(q_q + 2'd1) : q_q) : Q0;
    addr_d     = accept ? {addr, rw} : addr_q;
    wdata_d    = accept ? data_in : wdata_q;
    busy_d     = accept ? 1'b1 : (state_q == ST_STOP && bit_end) ? 1'b0 : busy_q;
    done_d     = state_q == ST_STOP && bit_end;
    ack_d      = sample ? sda_sync_q[1] : ack_q;
    rx_d       = (sample && state_q == ST_RDATA) ? {rx_q[6:0], sda_sync_q[1]} : rx_q;
    data_out_d = (bit_end && state_q == ST_ACK2 && rd) ? rx_q : data_out_q;
    ack_err_d  = accept ? 1'b0 :
                 (bit_end && ack_q && (state_q == ST_ACK1 || (state_q == ST_ACK2 && !rd))) ? 1'b1 :
                 ack_err_q;
    bit_cnt_d  = !bit_end ? bit_cnt_q :
                 state_q == ST_START ? CW'(ADDR_W) :
                 (state_q inside {ST_ADDR, ST_WDATA, ST_RDATA}) ? (last_bit ? CW'(7) : bit_cnt_q - CW'(1)) :
                 bit_cnt_q;
  end

  // Line drives are decoded from the next state and registered, so the pins
  // switch exactly on quarter boundaries without decode glitches.
  always_comb begin
    scl_low_d = scl_low_f(state_d, q_d);
    sda_low_d = state_d == ST_START ? q_d inside {Q2, Q3} :
                state_d == ST_ADDR  ? !addr_d[bit_cnt_d] :
                state_d == ST_WDATA ? !wdata_d[bit_cnt_d[2:0]] :
                state_d == ST_STOP  ? q_d != Q3 :
                1'b0;
  end

  assign sda      = sda_low_q ? 1'b0 : 1'bz;
  assign scl      = scl_low_q ? 1'b0 : 1'bz;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter DIV, default 4: clk cycles per SCL quarter-period; legal range is 2 or more.
REQ-002 SHALL have parameter ADDR_W, default 7: I2C address width.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-006 SHALL have port addr, input, 7 bits: target address, captured when start is accepted.
REQ-007 SHALL have port rw, input, 1 bit: 0 = write data_in to the target, 1 = read one byte from the target; captured with addr.
REQ-008 SHALL have port data_in, input, 8 bits: write byte, captured with addr.
REQ-009 SHALL have port data_out, output, 8 bits: last byte read; holds its value until the next read completes.
REQ-010 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at transaction end.
REQ-012 SHALL have port ack_err, output, 1 bit: the address or write byte was NACKed; valid with done and held until the next start.
REQ-013 SHALL have ports sda and scl, inout, 1 bit each: open-drain, driven 0 or released (Z), never driven 1.

Function
REQ-014 SHALL derive a quarter tick every DIV clk cycles while busy; each bit-time is four quarters Q0..Q3.
- Q0–Q1: SCL low.
- Q2–Q3: SCL released.
- SDA changes only at Q0 entry.
- SDA sampled at Q2 entry.
REQ-015 SHALL implement these states: IDLE, START, ADDR, ACK1, WDATA, RDATA, ACK2, STOP.
REQ-016 IDLE SHALL release sda and scl; start=1 SHALL latch the inputs, set busy, clear ack_err and enter START on the next cycle.
REQ-017 START SHALL last one bit-time.
- SDA is released in Q0–Q1 with SCL released.
- SDA falls at Q2 with SCL still released.
- SCL falls at Q3.
REQ-018 ADDR SHALL shift out {addr, rw} MSB first over 8 bit-times, then enter ACK1.
REQ-019 ACK1 SHALL release sda and sample it at Q2; the next state is chosen from the sample and rw:
- Sample 0 with rw=0: enter WDATA.
- Sample 0 with rw=1: enter RDATA.
- Sample 1: set ack_err and enter STOP.
REQ-020 WDATA SHALL shift out data_in MSB first over 8 bit-times, then enter ACK2, which samples the slave ACK; a 1 sets ack_err.
REQ-021 RDATA SHALL release sda and sample 8 bits MSB first into a shift register, then enter ACK2.
- In ACK2 the master releases sda (NACK) and does not sample.
- data_out is updated at the end of ACK2.
REQ-022 STOP SHALL last one bit-time.
- SDA is held low in Q0–Q1.
- SCL is released at Q2.
- SDA is released at Q3.
- done pulses for 1 cycle after Q3 ends.
- busy clears in the same cycle and the block returns to IDLE.
REQ-023 SHALL ignore start while busy; a new transaction may start in the cycle after done.
REQ-024 A full write or read with ACKs SHALL take 20 bit-times (80*DIV clk cycles) from start acceptance to done; an address NACK SHALL take 11 bit-times.
REQ-025 SHALL not implement clock stretching or arbitration; scl is never sampled.
REQ-026 Bit counter SHALL count 7 down to 0 and SHALL not wrap; leaving the state at 0 reloads it to 7.

Reset
REQ-027 On rst_n=0 the block SHALL asynchronously enter IDLE and clear the following:
- sda and scl released.
- busy, done and ack_err at 0.
- data_out = 8'h00.
- Counters at 0.
REQ-028 Reset mid-transaction SHALL release both lines within the same cycle and SHALL not generate a STOP; after release the block accepts start normally.

Structure
REQ-029 Shared package i2c_pkg SHALL hold the state encoding, the quarter-phase encoding and the default target address 7'h44.
REQ-030 Quarter-tick generation SHALL be a sub-module named i2c_clk_gen, with inputs clk, rst_n and en, and output tick.

Verification
REQ-031 Write: DIV=4, addr=7'h44, rw=0, data_in=8'hA5, bus slave attached -> both ACKs seen, ack_err=0, done at cycle 320, bus bits 0x88 then 0xA5.
REQ-032 Read: addr=7'h44, rw=1 with the slave returning 8'hCC -> data_out=8'hCC, 9th bit released (NACK), ack_err=0, done at cycle 320.
REQ-033 Address NACK: addr=7'h12 -> ack_err=1, no data bits on the bus, STOP present, done at cycle 176.
REQ-034 rst_n asserted during the 3rd data bit -> sda=Z and scl=Z immediately, busy=0; a following write to 7'h44 completes normally.
REQ-035 start held high through the whole transaction -> exactly one transaction per acceptance, and a second starts the cycle after done.
REQ-036 Bus checker on every run -> SDA never changes while SCL is high, except for START and STOP; sda and scl are never driven 1.
